// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for a shared 256Kx16 asynchronous SRAM.
// Each winning transaction runs IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> HOLD.
// Every pin value, DQ drive included, comes straight from a flop.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic        CLOCK,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [17:0] addr0,
    input  logic [17:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [1:0]  be0,
    input  logic [1:0]  be1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic [1:0]  grant,
    inout  wire  [15:0] sram_DQ_mem,
    output logic [17:0] sram_ADDR_mem,
    output logic        sram_UB_N_mem,
    output logic        sram_LB_N_mem,
    output logic        sram_WE_N_mem,
    output logic        sram_CE_N_mem,
    output logic        sram_OE_N_mem
);

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 2;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_owner, w_owner_nxt;
    logic            r_last_grant, w_last_nxt;
    logic            r_we, w_we_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [DW-1:0]   r_wdata, w_wdata_nxt;
    logic [BW-1:0]   r_be, w_be_nxt;
    logic            w_pick;
    logic            w_capture;

    logic            r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
    logic            w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n;
    logic [AW-1:0]   r_sram_addr, w_sram_addr;
    logic            r_dq_oe, w_dq_oe;
    logic [DW-1:0]   r_dq_out, w_dq_out;
    logic            r_ack0, r_ack1, w_ack0, w_ack1;
    logic [1:0]      r_grant, w_grant;
    logic [DW-1:0]   r_rdata0, r_rdata1, w_rdata0, w_rdata1;

    // Arbitration, sequencing and next values of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_grant;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_be_nxt    = r_be;
        w_pick      = 1'b0;
        w_capture   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && !req1)            w_pick = 1'b0;
                    else if (!req0 && req1)       w_pick = 1'b1;
                    else if (FIXED_PRIORITY != 0) w_pick = 1'b0;
                    else                          w_pick = ~r_last_grant;
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_we_nxt    = w_pick ? we1    : we0;
                    w_addr_nxt  = w_pick ? addr1  : addr0;
                    w_wdata_nxt = w_pick ? wdata1 : wdata0;
                    w_be_nxt    = w_pick ? be1    : be0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (r_cnt == CW'(WAIT_CYCLES - 1)) begin
                    w_capture   = ~r_we;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ce_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_ub_n      = 1'b1;
        w_lb_n      = 1'b1;
        w_sram_addr = '0;
        w_dq_oe     = 1'b0;
        w_dq_out    = w_wdata_nxt;
        w_grant     = 2'b00;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        w_rdata0    = r_rdata0;
        w_rdata1    = r_rdata1;

        if (w_state_nxt != S_IDLE) begin
            w_ce_n      = 1'b0;
            w_sram_addr = w_addr_nxt;
            w_ub_n      = ~w_be_nxt[1];
            w_lb_n      = ~w_be_nxt[0];
            w_dq_oe     = w_we_nxt;
            w_grant     = w_owner_nxt ? 2'b10 : 2'b01;
        end
        if (w_state_nxt == S_ACCESS) begin
            w_oe_n = w_we_nxt;
            w_we_n = ~w_we_nxt;
        end
        if (w_state_nxt == S_HOLD) begin
            w_ack0 = ~w_owner_nxt;
            w_ack1 = w_owner_nxt;
        end
        if (w_capture) begin
            if (r_owner) w_rdata1 = sram_DQ_mem;
            else         w_rdata0 = sram_DQ_mem;
        end
    end

    // State and access counter.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latched transaction, arbitration history and registered pin/port outputs.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_ub_n       <= 1'b1;
            r_lb_n       <= 1'b1;
            r_sram_addr  <= '0;
            r_dq_oe      <= 1'b0;
            r_dq_out     <= '0;
            r_grant      <= 2'b00;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_be         <= w_be_nxt;
            r_ce_n       <= w_ce_n;
            r_oe_n       <= w_oe_n;
            r_we_n       <= w_we_n;
            r_ub_n       <= w_ub_n;
            r_lb_n       <= w_lb_n;
            r_sram_addr  <= w_sram_addr;
            r_dq_oe      <= w_dq_oe;
            r_dq_out     <= w_dq_out;
            r_grant      <= w_grant;
            r_ack0       <= w_ack0;
            r_ack1       <= w_ack1;
            r_rdata0     <= w_rdata0;
            r_rdata1     <= w_rdata1;
        end
    end

    assign sram_DQ_mem   = r_dq_oe ? r_dq_out : {DW{1'bz}};
    assign sram_ADDR_mem = r_sram_addr;
    assign sram_CE_N_mem = r_ce_n;
    assign sram_OE_N_mem = r_oe_n;
    assign sram_WE_N_mem = r_we_n;
    assign sram_UB_N_mem = r_ub_n;
    assign sram_LB_N_mem = r_lb_n;
    assign ack0          = r_ack0;
    assign ack1          = r_ack1;
    assign grant         = r_grant;
    assign rdata0        = r_rdata0;
    assign rdata1        = r_rdata1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the DQ bus.
module tb_sram_arbiter;

    localparam logic [15:0] PROBE = 16'h5A5A;

    logic        CLOCK;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [17:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  be0, be1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  grant;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    logic        probe_en;
    logic [15:0] mem [0:262143];
    logic        mdl_rd;

    int total;
    int bad;

    sram_arbiter #(.WAIT_CYCLES(2), .FIXED_PRIORITY(0)) dut (
        .CLOCK(CLOCK), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1), .grant(grant),
        .sram_DQ_mem(sram_dq), .sram_ADDR_mem(sram_addr),
        .sram_UB_N_mem(ub_n), .sram_LB_N_mem(lb_n), .sram_WE_N_mem(we_n),
        .sram_CE_N_mem(ce_n), .sram_OE_N_mem(oe_n)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // SRAM model: drives DQ on reads; the probe lets the bench test that the DUT is off the bus.
    assign mdl_rd  = !ce_n && !oe_n && we_n;
    assign sram_dq = probe_en ? PROBE : (mdl_rd ? mem[sram_addr] : 16'hzzzz);

    // SRAM model write: byte lanes latched on the rising edge of WE_N.
    always @(posedge we_n) begin
        if (!ce_n) begin
            if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
            if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One transaction on a port; gathers strobe activity until its ack, then steps into IDLE.
    task automatic run_txn(input bit port, input logic wr, input logic [17:0] a,
                           input logic [15:0] d, input logic [1:0] b,
                           output int ce_c, output int we_c, output int oe_c,
                           output int ub_c, output int lb_c, output int ack_i,
                           output int dq_bad, output int probe_bad,
                           output logic [1:0] gnt, output logic [15:0] rd_at_ack);
        logic ackp;
        ce_c = 0; we_c = 0; oe_c = 0; ub_c = 0; lb_c = 0; ack_i = 0;
        dq_bad = 0; probe_bad = 0; gnt = 2'b00; rd_at_ack = 16'h0000;
        if (!port) begin
            req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = d; be0 = b;
        end else begin
            req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = d; be1 = b;
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLOCK);
            if (!ce_n) begin
                ce_c++;
                if (gnt == 2'b00) gnt = grant;
                if (wr && (sram_dq !== d)) dq_bad++;
            end
            if (!we_n) we_c++;
            if (!oe_n) oe_c++;
            if (!ub_n) ub_c++;
            if (!lb_n) lb_c++;
            if (!wr && !ce_n && oe_n) begin
                probe_en = 1'b1;
                #1;
                if (sram_dq !== PROBE) probe_bad++;
                probe_en = 1'b0;
            end
            ackp = port ? ack1 : ack0;
            if (ackp) begin
                ack_i     = i;
                rd_at_ack = port ? rdata1 : rdata0;
                break;
            end
        end
        if (!port) req0 = 1'b0;
        else       req1 = 1'b0;
        @(negedge CLOCK);
    endtask

    task automatic test_reset();
        logic [15:0] pv;
        reset = 1'b0; probe_en = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
        repeat (6) @(negedge CLOCK);
        reset = 1'b1;
        @(negedge CLOCK);
        total++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin bad++;
            $display("FAIL rst_strobes: got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant: got %b want 00", grant); end
        total++; if ({ack0, ack1} !== 2'b00) begin bad++; $display("FAIL rst_ack: got %b want 00", {ack0, ack1}); end
        total++; if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin bad++;
            $display("FAIL rst_rdata: got %h/%h want 0000/0000", rdata0, rdata1); end
        total++; if (sram_addr !== 18'h0) begin bad++; $display("FAIL rst_addr: got %h want 00000", sram_addr); end
        probe_en = 1'b1; #1; pv = sram_dq; probe_en = 1'b0;
        total++; if (pv !== PROBE) begin bad++; $display("FAIL rst_dq_z: got %h want %h", pv, PROBE); end
    endtask

    task automatic test_single_write();
        int ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad;
        logic [1:0] gnt; logic [15:0] rd; logic [15:0] pv;
        run_txn(1'b0, 1'b1, 18'h00012, 16'hA5C3, 2'b11,
                ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad, gnt, rd);
        total++; if (we_c !== 2) begin bad++; $display("FAIL wr_we_width: got %0d want 2", we_c); end
        total++; if (ce_c !== 4) begin bad++; $display("FAIL wr_ce_width: got %0d want 4", ce_c); end
        total++; if (oe_c !== 0) begin bad++; $display("FAIL wr_oe: got %0d want 0", oe_c); end
        total++; if (dq_bad !== 0) begin bad++; $display("FAIL wr_dq: got %0d bad cycles want 0", dq_bad); end
        total++; if (ack_i !== 4) begin bad++; $display("FAIL wr_ack_lat: got %0d want 4", ack_i); end
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_grant: got %b want 01", gnt); end
        total++; if ({ce_n, grant, ack0} !== 4'b1000) begin bad++;
            $display("FAIL wr_idle: got %b want 1000", {ce_n, grant, ack0}); end
        probe_en = 1'b1; #1; pv = sram_dq; probe_en = 1'b0;
        total++; if (pv !== PROBE) begin bad++; $display("FAIL wr_idle_dq_z: got %h want %h", pv, PROBE); end
        total++; if (mem[18'h00012] !== 16'hA5C3) begin bad++;
            $display("FAIL wr_mem: got %h want a5c3", mem[18'h00012]); end
    endtask

    task automatic test_read_back();
        int ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad;
        logic [1:0] gnt; logic [15:0] rd;
        run_txn(1'b1, 1'b0, 18'h00012, 16'h0000, 2'b11,
                ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad, gnt, rd);
        total++; if (oe_c !== 2) begin bad++; $display("FAIL rd_oe_width: got %0d want 2", oe_c); end
        total++; if (we_c !== 0) begin bad++; $display("FAIL rd_we: got %0d want 0", we_c); end
        total++; if (probe_bad !== 0) begin bad++; $display("FAIL rd_dq_undriven: got %0d want 0", probe_bad); end
        total++; if (rd !== 16'hA5C3) begin bad++; $display("FAIL rd_rdata1: got %h want a5c3", rd); end
        total++; if (ack_i !== 4) begin bad++; $display("FAIL rd_ack_lat: got %0d want 4", ack_i); end
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rd_grant: got %b want 10", gnt); end
        total++; if (rdata0 !== 16'h0000) begin bad++; $display("FAIL rd_rdata0_kept: got %h want 0000", rdata0); end
    endtask

    task automatic test_contention();
        int a0, a1, ng, last_ack, nacks, space_bad;
        logic [1:0] gseq [6];
        logic [1:0] prev_g;
        logic [1:0] exp_g;
        a0 = 0; a1 = 0; ng = 0; last_ack = 0; nacks = 0; space_bad = 0; prev_g = 2'b00;
        for (int k = 0; k < 6; k++) gseq[k] = 2'b00;
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00100; wdata0 = 16'h1111; be0 = 2'b11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 18'h00200; wdata1 = 16'h2222; be1 = 2'b11;
        for (int i = 1; i <= 80; i++) begin
            @(negedge CLOCK);
            if (grant != 2'b00 && prev_g == 2'b00) begin
                if (ng < 6) gseq[ng] = grant;
                ng++;
            end
            prev_g = grant;
            if (ack0 || ack1) begin
                if (nacks > 0 && (i - last_ack) != 5) space_bad++;
                last_ack = i;
                nacks++;
            end
            if (ack0) begin a0++; if (a0 >= 3) req0 = 1'b0; end
            if (ack1) begin a1++; if (a1 >= 3) req1 = 1'b0; end
            if (a0 >= 3 && a1 >= 3) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) begin
            @(negedge CLOCK);
            if (ack0) a0++;
            if (ack1) a1++;
        end
        total++; if (ng !== 6) begin bad++; $display("FAIL ct_grant_count: got %0d want 6", ng); end
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (gseq[k] !== exp_g) begin bad++;
                $display("FAIL ct_grant_seq[%0d]: got %b want %b", k, gseq[k], exp_g); end
        end
        total++; if (a0 !== 3) begin bad++; $display("FAIL ct_ack0_count: got %0d want 3", a0); end
        total++; if (a1 !== 3) begin bad++; $display("FAIL ct_ack1_count: got %0d want 3", a1); end
        total++; if (space_bad !== 0) begin bad++; $display("FAIL ct_ack_spacing: got %0d bad gaps want 0", space_bad); end
        total++; if (rdata1 !== 16'hA5C3) begin bad++; $display("FAIL ct_rdata1_kept: got %h want a5c3", rdata1); end
        total++; if (mem[18'h00200] !== 16'h2222) begin bad++;
            $display("FAIL ct_mem1: got %h want 2222", mem[18'h00200]); end
    endtask

    task automatic test_byte_enable();
        int ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad;
        logic [1:0] gnt; logic [15:0] rd;
        run_txn(1'b1, 1'b1, 18'h00012, 16'h1234, 2'b10,
                ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad, gnt, rd);
        total++; if (ub_c !== 4) begin bad++; $display("FAIL be_ub: got %0d want 4", ub_c); end
        total++; if (lb_c !== 0) begin bad++; $display("FAIL be_lb: got %0d want 0", lb_c); end
        total++; if (mem[18'h00012] !== 16'h12C3) begin bad++;
            $display("FAIL be_mem: got %h want 12c3", mem[18'h00012]); end
        run_txn(1'b0, 1'b0, 18'h00012, 16'h0000, 2'b11,
                ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad, gnt, rd);
        total++; if (rd !== 16'h12C3) begin bad++; $display("FAIL be_rdata0: got %h want 12c3", rd); end
        total++; if (rdata1 !== 16'hA5C3) begin bad++; $display("FAIL be_rdata1_kept: got %h want a5c3", rdata1); end
    endtask

    task automatic test_be_zero();
        int ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad;
        logic [1:0] gnt; logic [15:0] rd;
        run_txn(1'b0, 1'b1, 18'h00012, 16'hFFFF, 2'b00,
                ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad, gnt, rd);
        total++; if (ub_c + lb_c !== 0) begin bad++; $display("FAIL be0_lanes: got %0d want 0", ub_c + lb_c); end
        total++; if (ack_i !== 4) begin bad++; $display("FAIL be0_ack: got %0d want 4", ack_i); end
        total++; if (mem[18'h00012] !== 16'h12C3) begin bad++;
            $display("FAIL be0_mem: got %h want 12c3", mem[18'h00012]); end
    endtask

    task automatic test_reset_mid();
        int ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad, acks, seen;
        logic [1:0] gnt; logic [15:0] rd; logic [15:0] pv;
        seen = 0; acks = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00040; wdata0 = 16'h7777; be0 = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK);
            if (!we_n) begin seen = 1; break; end
        end
        total++; if (seen !== 1) begin bad++; $display("FAIL mid_reach_access: got %0d want 1", seen); end
        reset = 1'b0;
        #1;
        total++; if ({we_n, ce_n, oe_n, grant} !== 5'b11100) begin bad++;
            $display("FAIL mid_async_strobes: got %b want 11100", {we_n, ce_n, oe_n, grant}); end
        probe_en = 1'b1; #1; pv = sram_dq; probe_en = 1'b0;
        total++; if (pv !== PROBE) begin bad++; $display("FAIL mid_dq_z: got %h want %h", pv, PROBE); end
        repeat (3) begin
            @(negedge CLOCK);
            if (ack0) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL mid_no_ack: got %0d want 0", acks); end
        reset = 1'b1;
        run_txn(1'b0, 1'b1, 18'h00040, 16'h7777, 2'b11,
                ce_c, we_c, oe_c, ub_c, lb_c, ack_i, dq_bad, probe_bad, gnt, rd);
        total++; if (ack_i !== 4) begin bad++; $display("FAIL mid_resume_ack: got %0d want 4", ack_i); end
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_resume_grant: got %b want 01", gnt); end
        total++; if (mem[18'h00040] !== 16'h7777) begin bad++;
            $display("FAIL mid_resume_mem: got %h want 7777", mem[18'h00040]); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_byte_enable();
        test_be_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
